fb_rect_fill: RTL and testbench

- Memory-mapped rectangle-fill engine feeding the 80x60 double-buffered HDMI framebuffer, directly upstream of it.
- CPU programs position, size, colour and target segment over an iomem slave port, then sets start.
- Engine masters the framebuffer's iomem write port, one 24-bit pixel word per handshake, then reports done.
- Offloads the CPU from per-pixel store loops during clears and sprite/box drawing.

---
 rtl/fb_rect_pkg.sv | 27 ++
 rtl/fb_rect_fill_addr_gen.sv | 90 +++++++++
 rtl/fb_rect_fill.sv | 196 +++++++++++++++++++
 tb/tb_fb_rect_fill.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_rect_pkg.sv
// Shared constants, register map and state encoding for the framebuffer
// rectangle-fill engine.
package fb_rect_pkg;

  localparam logic [31:0] FB_ADDR0_DEF  = 32'h1000_0000;
  localparam logic [31:0] FB_ADDR1_DEF  = 32'h1000_8000;
  localparam logic [31:0] CTRL_BASE_DEF = 32'h3000_0030;
  localparam int          XRES_DEF      = 80;
  localparam int          YRES_DEF      = 60;

  localparam logic [3:0] M_WSTRB = 4'b0111;

  // Word index within the register window (byte address bits [3:2])
  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_POS   = 2'd1;
  localparam logic [1:0] REG_SIZE  = 2'd2;
  localparam logic [1:0] REG_COLOR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLIP = 3'd1,
    ST_WR   = 3'd2,
    ST_ADV  = 3'd3,
    ST_FIN  = 3'd4
  } fill_state_e;

endpackage

// File: rtl/fb_rect_fill_addr_gen.sv
// Column/row counters and pixel address stepping for one rectangle fill.
// Clipping to the screen edge is computed here and loaded on the clip strobe.
module fb_rect_addr_gen
  import fb_rect_pkg::*;
#(
  parameter int XRES = XRES_DEF,
  parameter int YRES = YRES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clip,
  input  logic        adv,
  input  logic [6:0]  x0,
  input  logic [5:0]  y0,
  input  logic [6:0]  w,
  input  logic [5:0]  h,
  input  logic [31:0] base,
  output logic        empty,
  output logic        last,
  output logic [31:0] addr
);

  localparam logic [6:0]  XRES_W     = 7'(XRES);
  localparam logic [5:0]  YRES_W     = 6'(YRES);
  localparam logic [31:0] ROW_STRIDE = 32'(XRES * 4);

  logic [6:0]  x_room_s;
  logic [5:0]  y_room_s;
  logic [6:0]  weff_s;
  logic [5:0]  heff_s;
  logic [31:0] y_off_s;
  logic [31:0] pix_off_s;
  logic [31:0] start_addr_s;
  logic [6:0]  col_inc_s;
  logic [5:0]  row_inc_s;

  logic [6:0]  col_r;
  logic [5:0]  row_r;
  logic [6:0]  weff_r;
  logic [5:0]  heff_r;
  logic [31:0] row_addr_r;
  logic [31:0] addr_r;

  assign empty = (x0 >= XRES_W) || (y0 >= YRES_W) || (w == 7'd0) || (h == 6'd0);

  assign x_room_s = XRES_W - x0;
  assign y_room_s = YRES_W - y0;
  assign weff_s   = (w < x_room_s) ? w : x_room_s;
  assign heff_s   = (h < y_room_s) ? h : y_room_s;

  // y0*80 as two shifts; this ties the row multiply to an 80-pixel line
  assign y_off_s      = ({26'h0, y0} << 6) + ({26'h0, y0} << 4);
  assign pix_off_s    = y_off_s + {25'h0, x0};
  assign start_addr_s = base + (pix_off_s << 2);

  assign col_inc_s = col_r + 7'd1;
  assign row_inc_s = row_r + 6'd1;
  assign last      = (col_inc_s >= weff_r) && (row_inc_s >= heff_r);
  assign addr      = addr_r;

  // Counters and addresses: loaded at clip, stepped once per accepted pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r      <= 7'd0;
      row_r      <= 6'd0;
      weff_r     <= 7'd0;
      heff_r     <= 6'd0;
      row_addr_r <= 32'h0;
      addr_r     <= 32'h0;
    end else if (clip) begin
      col_r      <= 7'd0;
      row_r      <= 6'd0;
      weff_r     <= weff_s;
      heff_r     <= heff_s;
      row_addr_r <= start_addr_s;
      addr_r     <= start_addr_s;
    end else if (adv) begin
      if (col_inc_s < weff_r) begin
        col_r  <= col_inc_s;
        addr_r <= addr_r + 32'd4;
      end else if (row_inc_s < heff_r) begin
        col_r      <= 7'd0;
        row_r      <= row_inc_s;
        row_addr_r <= row_addr_r + ROW_STRIDE;
        addr_r     <= row_addr_r + ROW_STRIDE;
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Memory-mapped rectangle-fill engine: a CPU register window on the slave
// port, and a one-pixel-per-handshake master into the framebuffer.
module fb_rect_fill
  import fb_rect_pkg::*;
#(
  parameter logic [31:0] FB_ADDR0  = FB_ADDR0_DEF,
  parameter logic [31:0] FB_ADDR1  = FB_ADDR1_DEF,
  parameter logic [31:0] CTRL_BASE = CTRL_BASE_DEF,
  parameter int          XRES      = XRES_DEF,
  parameter int          YRES      = YRES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        s_sel,
  input  logic [3:0]  s_wstrb,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        busy
);

  fill_state_e state_r, state_next_s;

  logic        hit_s;
  logic [1:0]  reg_idx_s;
  logic        wr_en_s;
  logic        start_s;
  logic        clip_s;
  logic        adv_s;
  logic        empty_s;
  logic        last_s;
  logic [31:0] base_s;
  logic [31:0] addr_s;
  logic [31:0] rdata_s;
  logic        unused_ok_s;

  logic        s_ready_r;
  logic        m_valid_r;
  logic        busy_r;
  logic        done_r;
  logic        seg_r;
  logic [6:0]  x0_r;
  logic [5:0]  y0_r;
  logic [6:0]  w_r;
  logic [5:0]  h_r;
  logic [23:0] color_r;

  assign hit_s     = s_valid && (s_addr[31:4] == CTRL_BASE[31:4]);
  assign reg_idx_s = s_addr[3:2];
  // Register contents are frozen for the whole fill; writes are still acked
  assign wr_en_s   = hit_s && !s_ready_r && (s_wstrb != 4'b0000) && !busy_r;
  assign start_s   = wr_en_s && (reg_idx_s == REG_CTRL) && s_wdata[0] && (state_r == ST_IDLE);
  assign base_s    = seg_r ? FB_ADDR1 : FB_ADDR0;

  assign unused_ok_s = ^{s_addr[1:0], s_wdata[31:24]};

  assign s_ready = s_ready_r;
  assign s_sel   = hit_s;
  assign s_rdata = rdata_s;
  assign m_valid = m_valid_r;
  assign m_wstrb = m_valid_r ? M_WSTRB : 4'b0000;
  assign m_addr  = addr_s;
  assign m_wdata = {8'h00, color_r};
  assign busy    = busy_r;

  fb_rect_addr_gen #(
    .XRES (XRES),
    .YRES (YRES)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clip  (clip_s),
    .adv   (adv_s),
    .x0    (x0_r),
    .y0    (y0_r),
    .w     (w_r),
    .h     (h_r),
    .base  (base_s),
    .empty (empty_s),
    .last  (last_s),
    .addr  (addr_s)
  );

  // Slave response: one-cycle ready pulse per decoded access
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready_r <= 1'b0;
    end else begin
      s_ready_r <= hit_s && !s_ready_r;
    end
  end

  // Register file writes
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r   <= 1'b0;
      x0_r    <= 7'd0;
      y0_r    <= 6'd0;
      w_r     <= 7'd0;
      h_r     <= 6'd0;
      color_r <= 24'h0;
    end else if (wr_en_s) begin
      case (reg_idx_s)
        REG_CTRL:  seg_r <= s_wdata[1];
        REG_POS: begin
          x0_r <= s_wdata[6:0];
          y0_r <= s_wdata[21:16];
        end
        REG_SIZE: begin
          w_r <= s_wdata[6:0];
          h_r <= s_wdata[21:16];
        end
        REG_COLOR: color_r <= s_wdata[23:0];
        default:   color_r <= color_r;
      endcase
    end
  end

  // Register read mux, combinational while the access is presented
  always_comb begin
    rdata_s = 32'h0;
    if (hit_s && (s_wstrb == 4'b0000)) begin
      case (reg_idx_s)
        REG_CTRL:  rdata_s = {29'h0, done_r, seg_r, busy_r};
        REG_POS:   rdata_s = {10'h0, y0_r, 9'h0, x0_r};
        REG_SIZE:  rdata_s = {10'h0, h_r, 9'h0, w_r};
        REG_COLOR: rdata_s = {8'h00, color_r};
        default:   rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  // Busy spans CLIP through FIN; done is sticky until the next start
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start_s) begin
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (state_r == ST_FIN) begin
      busy_r <= 1'b0;
      done_r <= 1'b1;
    end
  end

  // Fill FSM state register and registered master valid
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      m_valid_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      m_valid_r <= (state_next_s == ST_WR);
    end
  end

  // Fill FSM next state and counter strobes
  always_comb begin
    state_next_s = state_r;
    clip_s       = 1'b0;
    adv_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_next_s = ST_CLIP;
        else         state_next_s = ST_IDLE;
      end
      ST_CLIP: begin
        clip_s = !empty_s;
        if (empty_s) state_next_s = ST_FIN;
        else         state_next_s = ST_WR;
      end
      ST_WR: begin
        if (m_ready) state_next_s = ST_ADV;
        else         state_next_s = ST_WR;
      end
      ST_ADV: begin
        adv_s = 1'b1;
        if (last_s) state_next_s = ST_FIN;
        else        state_next_s = ST_WR;
      end
      ST_FIN:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Scoreboard bench for fb_rect_fill: directed fills push expected pixel
// writes, a monitor pops and compares them at every master handshake.
module tb_fb_rect_fill;

  localparam logic [31:0] CTRL_A  = 32'h3000_0030;
  localparam logic [31:0] POS_A   = 32'h3000_0034;
  localparam logic [31:0] SIZE_A  = 32'h3000_0038;
  localparam logic [31:0] COLOR_A = 32'h3000_003C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready, s_sel;
  logic [3:0]  s_wstrb = 4'h0;
  logic [31:0] s_addr = 32'h0;
  logic [31:0] s_wdata = 32'h0;
  logic [31:0] s_rdata;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        busy;

  fb_rect_fill dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } px_t;

  px_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  int          vcycles = 0;
  int          stall_cycles = 0;
  int          slow_idx = -1;
  bit          rdy_hold = 1'b0;
  logic [31:0] last_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Framebuffer-side responder: ready after a per-pixel delay, one cycle wide
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (m_ready) begin
        m_ready = 1'b0;
        wcnt = 0;
      end else if (m_valid && !rdy_hold) begin
        if (wcnt >= ((hs_count == slow_idx) ? 5 : 0)) m_ready = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: scoreboard pop on handshake, stability check during stalls
  initial begin
    px_t         e;
    bit          pend;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_strb;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid) vcycles++;
      if (m_valid && pend) begin
        check("hold_addr", m_addr, h_addr);
        check("hold_data", m_wdata, h_data);
        check("hold_strb", {28'h0, m_wstrb}, {28'h0, h_strb});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h required=none", m_addr);
        end else begin
          e = exp_q.pop_front();
          check("px_addr", m_addr, e.addr);
          check("px_data", m_wdata, e.data);
          check("px_strb", {28'h0, m_wstrb}, 32'h7);
        end
        hs_count++;
        last_addr = m_addr;
        pend = 1'b0;
      end else if (m_valid) begin
        stall_cycles++;
        pend = 1'b1;
        h_addr = m_addr;
        h_data = m_wdata;
        h_strb = m_wstrb;
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    s_valid = 1'b1; s_addr = a; s_wdata = d; s_wstrb = 4'hF;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_ready && n < 8);
    check("wr_ack", {31'h0, s_ready}, 32'h1);
    s_valid = 1'b0; s_wstrb = 4'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    s_valid = 1'b1; s_addr = a; s_wstrb = 4'h0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_ready && n < 8);
    check("rd_ack", {31'h0, s_ready}, 32'h1);
    check("rd_sel", {31'h0, s_sel}, 32'h1);
    d = s_rdata;
    s_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20000) begin n++; @(posedge clk); #1; end
    if (n >= 20000) check("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic push_px(input logic [31:0] a, input logic [23:0] col);
    px_t e;
    e.addr = a;
    e.data = {8'h00, col};
    exp_q.push_back(e);
  endtask

  task automatic push_rect(input int x0, input int y0, input int w, input int h,
                           input bit seg, input logic [23:0] col);
    logic [31:0] base;
    base = seg ? 32'h1000_8000 : 32'h1000_0000;
    for (int y = y0; y < y0 + h && y < 60; y++)
      for (int x = x0; x < x0 + w && x < 80; x++)
        push_px(base + 32'((y * 80 + x) * 4), col);
  endtask

  initial begin
    int          n, hs0;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", {31'h0, m_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_sready", {31'h0, s_ready}, 32'h0);
    reset = 1'b0;
    read_check("rst_ctrl", CTRL_A, 32'h0);
    read_check("rst_pos", POS_A, 32'h0);
    read_check("rst_size", SIZE_A, 32'h0);
    read_check("rst_color", COLOR_A, 32'h0);
    s_valid = 1'b1; s_addr = 32'h3000_0040; s_wstrb = 4'h0;
    #1;
    check("miss_sel", {31'h0, s_sel}, 32'h0);
    check("miss_rdata", s_rdata, 32'h0);
    s_valid = 1'b0;

    // 3x2 at (2,3), segment 0
    cpu_write(POS_A, 32'h0003_0002);
    cpu_write(SIZE_A, 32'h0002_0003);
    cpu_write(COLOR_A, 32'h00FF_8000);
    read_check("pos_rb", POS_A, 32'h0003_0002);
    push_px(32'h1000_03C8, 24'hFF8000);
    push_px(32'h1000_03CC, 24'hFF8000);
    push_px(32'h1000_03D0, 24'hFF8000);
    push_px(32'h1000_0508, 24'hFF8000);
    push_px(32'h1000_050C, 24'hFF8000);
    push_px(32'h1000_0510, 24'hFF8000);
    cpu_write(CTRL_A, 32'h1);
    wait_idle(n);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    read_check("t1_ctrl", CTRL_A, 32'h4);

    // 10x10 at (78,59), segment 1: clipped to 2x1, (59*80+78)*4 = 0x4AF8
    cpu_write(POS_A, 32'h003B_004E);
    cpu_write(SIZE_A, 32'h000A_000A);
    push_px(32'h1000_CAF8, 24'hFF8000);
    push_px(32'h1000_CAFC, 24'hFF8000);
    hs0 = hs_count;
    cpu_write(CTRL_A, 32'h3);
    wait_idle(n);
    check("t2_count", 32'(hs_count - hs0), 32'd2);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    read_check("t2_ctrl", CTRL_A, 32'h6);

    // x0 off-screen, then zero width: nothing written
    cpu_write(POS_A, 32'h0000_0050);
    cpu_write(SIZE_A, 32'h0003_0003);
    vcycles = 0;
    cpu_write(CTRL_A, 32'h1);
    wait_idle(n);
    check("e1_busy_cycles", 32'(n), 32'd2);
    check("e1_valid_cycles", 32'(vcycles), 32'd0);
    read_check("e1_ctrl", CTRL_A, 32'h4);
    cpu_write(POS_A, 32'h0000_0000);
    cpu_write(SIZE_A, 32'h0005_0000);
    vcycles = 0;
    cpu_write(CTRL_A, 32'h1);
    wait_idle(n);
    check("e2_busy_cycles", 32'(n), 32'd2);
    check("e2_valid_cycles", 32'(vcycles), 32'd0);
    read_check("e2_ctrl", CTRL_A, 32'h4);

    // 4x1 at (10,10) with the second pixel stalled for 5 cycles
    cpu_write(POS_A, 32'h000A_000A);
    cpu_write(SIZE_A, 32'h0001_0004);
    cpu_write(COLOR_A, 32'h0012_3456);
    push_rect(10, 10, 4, 1, 1'b0, 24'h123456);
    hs0 = hs_count;
    slow_idx = hs_count + 1;
    stall_cycles = 0;
    cpu_write(CTRL_A, 32'h1);
    wait_idle(n);
    slow_idx = -1;
    check("slow_stalls", 32'(stall_cycles), 32'd5);
    check("slow_count", 32'(hs_count - hs0), 32'd4);
    check("slow_drained", 32'(exp_q.size()), 32'd0);

    // Full screen, with COLOR/POS/CTRL writes landing while busy
    cpu_write(POS_A, 32'h0000_0000);
    cpu_write(SIZE_A, 32'h003C_0050);
    cpu_write(COLOR_A, 32'h00AB_CDEF);
    push_rect(0, 0, 80, 60, 1'b0, 24'hABCDEF);
    hs0 = hs_count;
    cpu_write(CTRL_A, 32'h1);
    cpu_write(COLOR_A, 32'h0011_1111);
    cpu_write(POS_A, 32'h0005_0005);
    cpu_write(CTRL_A, 32'h3);
    wait_idle(n);
    check("full_count", 32'(hs_count - hs0), 32'd4800);
    check("full_last", last_addr, 32'h1000_4AFC);
    check("full_drained", 32'(exp_q.size()), 32'd0);
    read_check("full_color", COLOR_A, 32'h00AB_CDEF);
    read_check("full_ctrl", CTRL_A, 32'h4);

    // 10x10 fill reset while the third pixel is pending
    cpu_write(POS_A, 32'h0005_0005);
    cpu_write(SIZE_A, 32'h000A_000A);
    cpu_write(COLOR_A, 32'h00C0_FFEE);
    push_rect(5, 5, 10, 10, 1'b0, 24'hC0FFEE);
    hs0 = hs_count;
    cpu_write(CTRL_A, 32'h1);
    n = 0;
    while (hs_count < hs0 + 2 && n < 200) begin @(posedge clk); #1; n++; end
    rdy_hold = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("rst3_valid_seen", {31'h0, m_valid}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst3_mvalid", {31'h0, m_valid}, 32'h0);
    check("rst3_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    rdy_hold = 1'b0;
    check("rst3_count", 32'(hs_count - hs0), 32'd2);
    exp_q.delete();
    read_check("rst3_ctrl", CTRL_A, 32'h0);
    read_check("rst3_pos", POS_A, 32'h0);
    read_check("rst3_size", SIZE_A, 32'h0);
    read_check("rst3_color", COLOR_A, 32'h0);

    // Fresh 2x2 at (1,1) after the reset
    cpu_write(POS_A, 32'h0001_0001);
    cpu_write(SIZE_A, 32'h0002_0002);
    cpu_write(COLOR_A, 32'h0000_00FF);
    push_px(32'h1000_0144, 24'h0000FF);
    push_px(32'h1000_0148, 24'h0000FF);
    push_px(32'h1000_0284, 24'h0000FF);
    push_px(32'h1000_0288, 24'h0000FF);
    hs0 = hs_count;
    cpu_write(CTRL_A, 32'h1);
    wait_idle(n);
    check("post_count", 32'(hs_count - hs0), 32'd4);
    check("post_drained", 32'(exp_q.size()), 32'd0);
    read_check("post_ctrl", CTRL_A, 32'h4);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
